// File: rtl/ef_gpio8_pkg.sv
// Shared constants and types for the EF_GPIO8 input-conditioning slice.
package ef_gpio8_pkg;

    localparam int unsigned GPIO_WIDTH      = 8;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned DB_W_DEF        = 8;

    typedef struct packed {
        logic rise;
        logic fall;
        logic hi;
        logic lo;
    } pin_evt_t;

endpackage

// File: rtl/ef_gpio8_pin_filter.sv
// One GPIO pin: synchroniser, optional debounce filter, previous-value flop and event decode.
module ef_gpio8_pin_filter
    import ef_gpio8_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned DB_W        = DB_W_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            pin_i,
    input  logic            db_en_i,
    input  logic [DB_W-1:0] db_thresh_i,
    output logic            filt_o,
    output pin_evt_t        evt_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_W-1:0]        cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   prev_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // The counter is cleared whenever it reaches the threshold, so it never wraps.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (!db_en_i) begin
            filt_d = s;
            cnt_d  = '0;
        end else if (s == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q >= db_thresh_i) begin
            filt_d = s;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            cnt_q  <= '0;
            filt_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            prev_q <= filt_q;
        end
    end

    assign filt_o     = filt_q;
    assign evt_o.rise = filt_q & ~prev_q;
    assign evt_o.fall = ~filt_q & prev_q;
    assign evt_o.hi   = filt_q;
    assign evt_o.lo   = ~filt_q;

endmodule

// File: rtl/ef_gpio8_in_cond.sv
// GPIO input conditioning: per-pin filters plus sticky interrupt status and combined IRQ.
module ef_gpio8_in_cond
    import ef_gpio8_pkg::*;
#(
    parameter int unsigned WIDTH       = GPIO_WIDTH,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned DB_W        = DB_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] io_in,
    input  logic [WIDTH-1:0] db_en,
    input  logic [DB_W-1:0]  db_thresh,
    input  logic [WIDTH-1:0] ie_rise,
    input  logic [WIDTH-1:0] ie_fall,
    input  logic [WIDTH-1:0] ie_hi,
    input  logic [WIDTH-1:0] ie_lo,
    input  logic [WIDTH-1:0] icr,
    output logic [WIDTH-1:0] data_o,
    output logic [WIDTH-1:0] ris_o,
    output logic             irq_o
);

    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] set;
    logic [WIDTH-1:0] ris_q, ris_d;
    pin_evt_t         evt [WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        ef_gpio8_pin_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_W        (DB_W)
        ) u_pin (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .pin_i       (io_in[i]),
            .db_en_i     (db_en[i]),
            .db_thresh_i (db_thresh),
            .filt_o      (filt[i]),
            .evt_o       (evt[i])
        );
    end

    always_comb begin
        set = '0;
        for (int i = 0; i < WIDTH; i++) begin
            set[i] = (evt[i].rise & ie_rise[i]) | (evt[i].fall & ie_fall[i]) |
                     (evt[i].hi & ie_hi[i]) | (evt[i].lo & ie_lo[i]);
        end
    end

    // A new event in the same cycle as a clear keeps the bit set.
    assign ris_d = (ris_q & ~icr) | set;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ris_q <= '0;
        end else begin
            ris_q <= ris_d;
        end
    end

    assign data_o = filt;
    assign ris_o  = ris_q;
    assign irq_o  = |ris_q;

endmodule

// File: tb/tb_ef_gpio8_in_cond.sv
// Bench for ef_gpio8_in_cond: vector table, directed multi-cycle sequences, random vs. model.
module tb_ef_gpio8_in_cond;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] io_in = '0, db_en = '0, db_thresh = '0;
    logic [7:0] ie_rise = '0, ie_fall = '0, ie_hi = '0, ie_lo = '0, icr = '0;
    logic [7:0] data_o, ris_o;
    logic       irq_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ef_gpio8_in_cond dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .io_in     (io_in),
        .db_en     (db_en),
        .db_thresh (db_thresh),
        .ie_rise   (ie_rise),
        .ie_fall   (ie_fall),
        .ie_hi     (ie_hi),
        .ie_lo     (ie_lo),
        .icr       (icr),
        .data_o    (data_o),
        .ris_o     (ris_o),
        .irq_o     (irq_o)
    );

    // Reference model: s is the pad value two clocks old; a pin's filtered value follows s
    // once s has disagreed with it for more than db_thresh consecutive clocks.
    logic [7:0] m_s0, m_s1, m_filt, m_prev, m_ris, m_filt_d, m_set;
    int         m_run [8];
    int         m_run_d [8];

    always_comb begin
        m_filt_d = m_filt;
        for (int i = 0; i < 8; i++) begin
            m_run_d[i] = m_run[i];
            if (!db_en[i]) begin
                m_filt_d[i] = m_s1[i];
                m_run_d[i]  = 0;
            end else if (m_s1[i] == m_filt[i]) begin
                m_run_d[i] = 0;
            end else if (m_run[i] >= int'(db_thresh)) begin
                m_filt_d[i] = m_s1[i];
                m_run_d[i]  = 0;
            end else begin
                m_run_d[i] = m_run[i] + 1;
            end
        end
        m_set = (m_filt & ~m_prev & ie_rise) | (~m_filt & m_prev & ie_fall) |
                (m_filt & ie_hi) | (~m_filt & ie_lo);
    end

    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            m_s0   <= '0;
            m_s1   <= '0;
            m_filt <= '0;
            m_prev <= '0;
            m_ris  <= '0;
            m_run  <= '{default: 0};
        end else begin
            m_s0   <= io_in;
            m_s1   <= m_s0;
            m_prev <= m_filt;
            m_filt <= m_filt_d;
            m_run  <= m_run_d;
            m_ris  <= (m_ris & ~icr) | m_set;
        end
    end

    typedef struct {
        logic [7:0] io, en, thr, rise, fall, hi, lo, clr;
        int         cyc;
        logic [7:0] data, ris;
    } vec_t;

    vec_t tbl [18];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change just after a falling edge; outputs are sampled on a falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_i   = 1'b1;
        io_in   = '0;
        db_en   = '0;
        db_thresh = '0;
        ie_rise = '0;
        ie_fall = '0;
        ie_hi   = '0;
        ie_lo   = '0;
        icr     = '0;
        step(2);
        rst_i = 1'b0;
    endtask

    initial begin
        //            io     en     thr    rise   fall   hi     lo     icr  cyc  data   ris
        tbl[0]  = '{8'h00, 8'h00, 8'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3, 8'h00, 8'h00};
        tbl[1]  = '{8'hA5, 8'h00, 8'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2, 8'h00, 8'h00};
        tbl[2]  = '{8'hA5, 8'h00, 8'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 8'hA5, 8'h00};
        tbl[3]  = '{8'h00, 8'h00, 8'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3, 8'h00, 8'h00};
        tbl[4]  = '{8'h0F, 8'h00, 8'h0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 3, 8'h0F, 8'h00};
        tbl[5]  = '{8'h0F, 8'h00, 8'h0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 1, 8'h0F, 8'h0F};
        tbl[6]  = '{8'h0F, 8'h00, 8'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 1, 8'h0F, 8'h00};
        tbl[7]  = '{8'h0F, 8'h00, 8'h0, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 1, 8'h0F, 8'h03};
        tbl[8]  = '{8'h0F, 8'h00, 8'h0, 8'h00, 8'h00, 8'h03, 8'h00, 8'hFF, 1, 8'h0F, 8'h03};
        tbl[9]  = '{8'h0F, 8'h00, 8'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 1, 8'h0F, 8'h00};
        tbl[10] = '{8'h0F, 8'h00, 8'h0, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 1, 8'h0F, 8'h80};
        tbl[11] = '{8'h8F, 8'h00, 8'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 1, 8'h0F, 8'h00};
        tbl[12] = '{8'h8F, 8'h00, 8'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2, 8'h8F, 8'h00};
        tbl[13] = '{8'h87, 8'h00, 8'h0, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 3, 8'h87, 8'h00};
        tbl[14] = '{8'h87, 8'h00, 8'h0, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 1, 8'h87, 8'h08};
        tbl[15] = '{8'h87, 8'h00, 8'h0, 8'h00, 8'h08, 8'h00, 8'h00, 8'h08, 1, 8'h87, 8'h00};
        tbl[16] = '{8'h00, 8'hFF, 8'h3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 5, 8'h87, 8'h00};
        tbl[17] = '{8'h00, 8'hFF, 8'h3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00};

        step(1);
        check("reset data", data_o, 8'h00);
        check("reset ris", ris_o, 8'h00);
        check("reset irq", {7'd0, irq_o}, 8'h00);
        rst_i = 1'b0;

        for (int k = 0; k < 18; k++) begin
            io_in     = tbl[k].io;
            db_en     = tbl[k].en;
            db_thresh = tbl[k].thr;
            ie_rise   = tbl[k].rise;
            ie_fall   = tbl[k].fall;
            ie_hi     = tbl[k].hi;
            ie_lo     = tbl[k].lo;
            icr       = tbl[k].clr;
            step(tbl[k].cyc);
            check($sformatf("vec%0d data", k), data_o, tbl[k].data);
            check($sformatf("vec%0d ris", k), ris_o, tbl[k].ris);
            check($sformatf("vec%0d irq", k), {7'd0, irq_o}, {7'd0, |tbl[k].ris});
        end

        // Debounce: a 3-cycle glitch is rejected, a held level passes after thresh+1 cycles.
        do_reset();
        db_en = 8'h01;
        db_thresh = 8'd4;
        ie_rise = 8'h01;
        io_in = 8'h01;
        step(3);
        io_in = 8'h00;
        step(10);
        check("glitch data", data_o, 8'h00);
        check("glitch ris", ris_o, 8'h00);
        io_in = 8'h01;
        step(6);
        check("db early data", data_o, 8'h00);
        step(1);
        check("db data", data_o, 8'h01);
        check("db ris early", ris_o, 8'h00);
        step(1);
        check("db ris", ris_o, 8'h01);
        check("db irq", {7'd0, irq_o}, 8'h01);

        // Clear in the same cycle as the rise event: the event wins.
        do_reset();
        ie_rise = 8'h02;
        io_in = 8'h02;
        step(3);
        check("sc data", data_o, 8'h02);
        icr = 8'h02;
        step(1);
        check("sc set wins", ris_o, 8'h02);
        step(1);
        check("sc clear", ris_o, 8'h00);
        icr = 8'h00;

        // Asynchronous reset in mid-count, then the debounce restarts from zero.
        do_reset();
        db_en = 8'h01;
        db_thresh = 8'd200;
        ie_hi = 8'h02;
        io_in = 8'h03;
        step(52);
        check("pre-rst data", data_o, 8'h02);
        check("pre-rst ris", ris_o, 8'h02);
        #2 rst_i = 1'b1;
        #1;
        check("async data", data_o, 8'h00);
        check("async ris", ris_o, 8'h00);
        check("async irq", {7'd0, irq_o}, 8'h00);
        @(negedge clk);
        rst_i = 1'b0;
        step(202);
        check("restart early", data_o & 8'h01, 8'h00);
        step(1);
        check("restart data", data_o & 8'h01, 8'h01);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c % 60 == 0) begin
                db_en     = 8'($urandom);
                db_thresh = 8'($urandom_range(0, 5));
                ie_rise   = 8'($urandom & $urandom);
                ie_fall   = 8'($urandom & $urandom);
                ie_hi     = 8'($urandom & $urandom & $urandom);
                ie_lo     = 8'($urandom & $urandom & $urandom);
            end
            if ($urandom_range(0, 2) == 0) io_in = io_in ^ 8'(1 << $urandom_range(0, 7));
            icr = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h00;
            step(1);
            check("rand data", data_o, m_filt);
            check("rand ris", ris_o, m_ris);
            check("rand irq", {7'd0, irq_o}, {7'd0, |m_ris});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ef_gpio8_in_cond.md
Name: ef_gpio8_in_cond

Overview:
Input-conditioning stage directly downstream of the EF_GPIO8 pads (io_in). It feeds the GPIO register file and IRQ logic.
- Per pin, it synchronises the asynchronous pad input, optionally debounces it with a programmable threshold, and detects edges and levels.
- It keeps sticky per-pin interrupt flags and drives a single combined interrupt request.
- The bus wrappers (APB/AHBL/WB) drive its configuration and clear inputs directly from GPIO registers.

Parameters:
WIDTH, 8, number of GPIO pins
SYNC_STAGES, 2, synchroniser flop depth (minimum 2)
DB_W, 8, debounce counter / threshold width

Ports:
clk_i  in  1  block clock
rst_i  in  1  asynchronous, active-high reset
io_in  in  WIDTH  raw pad inputs, asynchronous to clk_i
db_en  in  WIDTH  per-pin debounce enable
db_thresh  in  DB_W  shared debounce threshold, in cycles
ie_rise  in  WIDTH  rising-edge interrupt enable
ie_fall  in  WIDTH  falling-edge interrupt enable
ie_hi  in  WIDTH  high-level interrupt enable
ie_lo  in  WIDTH  low-level interrupt enable
icr  in  WIDTH  write-1-to-clear pulse for ris_o bits
data_o  out  WIDTH  conditioned (filtered) pin value
ris_o  out  WIDTH  sticky raw interrupt status
irq_o  out  1  OR-reduction of ris_o

Behaviour:
- Reset is asynchronous and active-high (rst_i). While asserted, all state clears to 0: sync chain, filtered value, prev value, counters, ris_o. Therefore data_o=0, ris_o=0, irq_o=0.
- Synchroniser: SYNC_STAGES flops per pin; s denotes the last stage.
- Debounce, per pin, db_en=1:
  - If s==filt, cnt<=0.
  - Else if cnt>=db_thresh, filt<=s and cnt<=0.
  - Else cnt<=cnt+1.
  - Comparison is >=, so lowering db_thresh mid-count takes effect on the next cycle.
  - cnt never exceeds db_thresh and cannot wrap.
- Debounce, db_en=0: filt<=s every cycle, cnt held at 0.
- Latency: io_in changes before edge N (SYNC_STAGES=2) -> data_o changes after edge N+2+T.
  - T = db_thresh when db_en=1; T = 0 when db_en=0.
  - A glitch shorter than db_thresh+1 consecutive cycles of s produces no data_o change.
- data_o = filt (registered, no combinational path from io_in).
- Edge detect: prev<=filt every cycle.
  - rise = filt & ~prev.
  - fall = ~filt & prev.
  - Each is a one-cycle pulse, one cycle after the filt change.
- Status: ris[i] next = (ris[i] & ~icr[i]) | set[i].
  - set[i] = (rise&ie_rise) | (fall&ie_fall) | (filt&ie_hi) | (~filt&ie_lo).
  - Simultaneous set and clear: set wins, the bit stays 1.
  - Level enables re-set the bit every cycle while the level holds, so clearing is ineffective until the level goes away or the enable is dropped.
- Toggling db_en or any ie_* mid-operation: takes effect on the next edge; no flush of cnt other than per the rules above.
- Out of reset, filt=0. A pin held high at rst_i release produces a rise event after T+3 cycles; software is expected to clear it.
- irq_o = |ris (combinational from flops only).
- Pins are fully independent; no cross-pin interaction except the shared db_thresh.

Decomposition:
- Package ef_gpio8_pkg:
  - constants GPIO_WIDTH=8, SYNC_STAGES_DEF=2, DB_W_DEF=8.
  - a typedef for the per-pin event struct {rise, fall, hi, lo}.
- Sub-module ef_gpio8_pin_filter: one pin's synchroniser, debounce counter, prev flop, and event outputs.
- Top ef_gpio8_in_cond instantiates WIDTH pin filters via generate and holds ris/irq logic.

Test Plan:
- Reset release with io_in=0x00, db_en=0, all ie=0; drive io_in=0xA5 before edge N -> data_o=0xA5 after edge N+2; ris_o=0, irq_o=0.
- db_en=0x01, db_thresh=4, ie_rise=0x01; pulse io_in[0] high for 3 cycles -> data_o[0] stays 0, ris_o=0. Hold it 5+ cycles -> data_o[0]=1 exactly 6 cycles after edge N; ris_o[0]=1 one cycle later; irq_o=1.
- ie_fall=0x80, db_en=0; drop io_in[7] 1->0 -> ris_o[7] set. Pulse icr=0x80 -> ris_o[7]=0 next cycle, irq_o=0.
- Simultaneous set and clear: ie_rise=0x02, icr[1] pulsed in the same cycle as the rise pulse -> ris_o[1]=1.
- ie_hi=0x04, io_in[2]=1 steady; pulse icr=0x04 -> ris_o[2] remains 1. Drop ie_hi, pulse icr -> ris_o[2]=0.
- db_thresh=200, mid-count (cnt≈50) assert rst_i asynchronously between clock edges -> data_o, ris_o, irq_o go 0 immediately. After release, the debounce restarts from cnt=0.
